// File: rtl/pe_pkg.sv
// Shared constants, sequencer state type and the slot-count clamp for pe_mac_seq.
package pe_pkg;

    localparam int unsigned DATA_W    = 16;  // Q7.9 operand/result width
    localparam int unsigned NUM_SLOTS = 8;   // accumulator slots in the PE
    localparam int unsigned SLOT_W    = 4;   // PE add/round slot select width
    localparam int unsigned DRAIN_CYC = 3;   // cycles for the last round to reach out_data

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } seq_state_t;

    // Zero vectors still means one; never more vectors than the PE has slots.
    function automatic logic [SLOT_W-1:0] clamp_slots(input logic [SLOT_W-1:0] cfg);
        if (cfg == '0) begin
            return SLOT_W'(1);
        end else if (cfg > SLOT_W'(NUM_SLOTS)) begin
            return SLOT_W'(NUM_SLOTS);
        end else begin
            return cfg;
        end
    endfunction

endpackage

// File: rtl/pe_mac_seq_if.sv
// Operand-pair stream into the sequencer.
//  s_valid/s_ready : handshake, a pair moves when both are high
//  s_a, s_b        : Q7.9 operand pair
//  s_last          : pair closes the current vector
interface pe_mac_seq_if;
    import pe_pkg::*;

    logic              s_valid;
    logic              s_ready;
    logic [DATA_W-1:0] s_a;
    logic [DATA_W-1:0] s_b;
    logic              s_last;

    modport master (output s_valid, s_a, s_b, s_last, input s_ready);
    modport slave  (input s_valid, s_a, s_b, s_last, output s_ready);
endinterface

// File: rtl/pe_seq_delay.sv
// Three-stage {valid,slot} shift that lines the PE controls up with its pipeline.
//  in_fire/in_last/in_slot : accepted pair, its last flag, its slot
//  add_slot                : stage 1, slot the PE adder writes (holds between fires)
//  round_en/round_slot     : stage 2, round request for a finished slot (slot holds)
//  out_en/out_slot         : stage 3, PE data_out carries that slot's result
module pe_seq_delay #(
    parameter int unsigned SLOT_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_fire,
    input  logic              in_last,
    input  logic [SLOT_W-1:0] in_slot,
    output logic [SLOT_W-1:0] add_slot,
    output logic              round_en,
    output logic [SLOT_W-1:0] round_slot,
    output logic              out_en,
    output logic [SLOT_W-1:0] out_slot
);

    logic last_q;

    // Slot fields load only when their stage carries a valid entry, so they hold otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q     <= 1'b0;
            add_slot   <= '0;
            round_en   <= 1'b0;
            round_slot <= '0;
            out_en     <= 1'b0;
            out_slot   <= '0;
        end else begin
            last_q   <= in_fire & in_last;
            round_en <= last_q;
            out_en   <= round_en;
            if (in_fire) begin
                add_slot <= in_slot;
            end
            if (last_q) begin
                round_slot <= add_slot;
            end
            if (round_en) begin
                out_slot <= round_slot;
            end
        end
    end

endmodule

// File: rtl/pe_mac_seq.sv
// Sequencer in front of one pe_unit: steers each operand vector into its own PE slot,
// rounds the slot once its last product has landed and flags the PE output as a result.
//  clk, rst                 : clock, async active-high reset (shared with the PE)
//  start, cfg_slots         : arm a pass of cfg_slots vectors (IDLE only)
//  s                        : operand-pair stream (slave side)
//  pe_data_1/2              : operands to the PE, zero when no pair moves
//  pe_add_number            : slot the PE adder accumulates into
//  pe_round_number/_en      : round request to the PE
//  pe_data_out              : PE result, passed through as out_data
//  out_valid/out_slot/out_data : finished slot result
//  done                     : pass complete, sticky until rst
module pe_mac_seq
    import pe_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [SLOT_W-1:0] cfg_slots,
    pe_mac_seq_if.slave       s,
    output logic [DATA_W-1:0] pe_data_1,
    output logic [DATA_W-1:0] pe_data_2,
    output logic [SLOT_W-1:0] pe_add_number,
    output logic [SLOT_W-1:0] pe_round_number,
    output logic              pe_rounder_en,
    input  logic [DATA_W-1:0] pe_data_out,
    output logic              out_valid,
    output logic [SLOT_W-1:0] out_slot,
    output logic [DATA_W-1:0] out_data,
    output logic              done
);

    seq_state_t        state_q, state_d;
    logic [SLOT_W-1:0] slot_ptr_q, slot_ptr_d;
    logic [SLOT_W-1:0] n_q, n_d;
    logic [1:0]        drain_q, drain_d;
    logic              ready_q, ready_d;
    logic              done_q, done_d;
    logic              fire;

    assign fire      = s.s_valid & ready_q;
    assign s.s_ready = ready_q;
    assign done      = done_q;

    // Idle operand lanes carry zero so the PE accumulates nothing on non-fire cycles.
    assign pe_data_1 = fire ? s.s_a : '0;
    assign pe_data_2 = fire ? s.s_b : '0;
    assign out_data  = pe_data_out;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            slot_ptr_q <= '0;
            n_q        <= '0;
            drain_q    <= '0;
            ready_q    <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            slot_ptr_q <= slot_ptr_d;
            n_q        <= n_d;
            drain_q    <= drain_d;
            ready_q    <= ready_d;
            done_q     <= done_d;
        end
    end

    // Next-state logic; ready/done are registered copies of the next state.
    always_comb begin
        state_d    = state_q;
        slot_ptr_d = slot_ptr_q;
        n_d        = n_q;
        drain_d    = drain_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = RUN;
                    n_d        = clamp_slots(cfg_slots);
                    slot_ptr_d = '0;
                end
            end
            RUN: begin
                if (fire && s.s_last) begin
                    slot_ptr_d = slot_ptr_q + SLOT_W'(1);
                    if (slot_ptr_q == n_q - SLOT_W'(1)) begin
                        state_d = DRAIN;
                        drain_d = '0;
                    end
                end
            end
            DRAIN: begin
                if (drain_q == 2'(DRAIN_CYC - 1)) begin
                    state_d = DONE;
                end else begin
                    drain_d = drain_q + 2'd1;
                end
            end
            DONE: begin
                state_d = DONE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        ready_d = (state_d == RUN);
        done_d  = (state_d == DONE);
    end

    pe_seq_delay #(
        .SLOT_W (SLOT_W)
    ) u_delay (
        .clk        (clk),
        .rst        (rst),
        .in_fire    (fire),
        .in_last    (s.s_last),
        .in_slot    (slot_ptr_q),
        .add_slot   (pe_add_number),
        .round_en   (pe_rounder_en),
        .round_slot (pe_round_number),
        .out_en     (out_valid),
        .out_slot   (out_slot)
    );

endmodule
